// File: rtl/div_reconstruct_mul_if.sv
// Operand/result stream between a producer and div_reconstruct_mul.
// With RECON_CHECK_EN defined, the stream also carries x_exp and mismatch.
interface div_reconstruct_mul_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned XW = 2 * N + 1;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  Q;
    logic [N-1:0]  Y;
    logic [N:0]    R;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] X;
`ifdef RECON_CHECK_EN
    logic [N-1:0]  x_exp;
    logic          mismatch;

    modport master (output in_valid, Q, Y, R, out_ready, x_exp,
                    input  in_ready, out_valid, X, mismatch);
    modport slave  (input  in_valid, Q, Y, R, out_ready, x_exp,
                    output in_ready, out_valid, X, mismatch);
`else
    modport master (output in_valid, Q, Y, R, out_ready,
                    input  in_ready, out_valid, X);
    modport slave  (input  in_valid, Q, Y, R, out_ready,
                    output in_ready, out_valid, X);
`endif
endinterface

// File: rtl/div_reconstruct_mul.sv
// Rebuilds a dividend X = Q*Y + R one quotient bit per clock (shift-add).
// Optional RECON_CHECK_EN adds an x_exp compare with a registered mismatch flag.
module div_reconstruct_mul #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst_n,
    div_reconstruct_mul_if.slave bus
);
    localparam int unsigned XW = 2 * N + 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [XW-1:0] x_q, x_d;
    logic [N-1:0]  q_sh, q_d;
    logic [XW-1:0] y_sh, y_d;
    logic [XW-1:0] acc, acc_d;
    logic [XW-1:0] acc_sum;
    logic [CW-1:0] cnt, cnt_d;
`ifdef RECON_CHECK_EN
    logic [N-1:0]  x_exp_q, x_exp_d;
    logic          mismatch_q, mismatch_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            q_sh        <= '0;
            y_sh        <= '0;
            acc         <= '0;
            cnt         <= '0;
`ifdef RECON_CHECK_EN
            x_exp_q     <= '0;
            mismatch_q  <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            q_sh        <= q_d;
            y_sh        <= y_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
`ifdef RECON_CHECK_EN
            x_exp_q     <= x_exp_d;
            mismatch_q  <= mismatch_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        x_d         = x_q;
        q_d         = q_sh;
        y_d         = y_sh;
        acc_d       = acc;
        cnt_d       = cnt;
`ifdef RECON_CHECK_EN
        x_exp_d     = x_exp_q;
        mismatch_d  = mismatch_q;
`endif
        acc_sum     = acc + (q_sh[0] ? y_sh : XW'(0));

        unique case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    q_d        = bus.Q;
                    y_d        = XW'(bus.Y);
                    acc_d      = {{N{bus.R[N]}}, bus.R};
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
`ifdef RECON_CHECK_EN
                    x_exp_d    = bus.x_exp;
`endif
                end
            end
            CALC: begin
                acc_d = acc_sum;
                y_d   = y_sh << 1;
                q_d   = q_sh >> 1;
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    x_d         = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef RECON_CHECK_EN
                    mismatch_d  = (acc_sum != XW'(x_exp_q));
`endif
                end
            end
            DONE: begin
                // X is left as-is after the handshake
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.X         = x_q;
`ifdef RECON_CHECK_EN
    assign bus.mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_div_reconstruct_mul.sv
// Scoreboard bench for div_reconstruct_mul (N=4): expected X pushed at capture,
// popped at the output handshake.
module tb_div_reconstruct_mul;
    localparam int unsigned N  = 4;
    localparam int unsigned XW = 2 * N + 1;

    typedef struct {
        logic [XW-1:0] x;
        logic          mm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    div_reconstruct_mul_if #(.N(N)) bus ();

    div_reconstruct_mul #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] q, input logic [3:0] y,
                                   input logic [4:0] r, input logic [3:0] xe);
        int   rs;
        int   v;
        exp_t e;
        rs   = r[4] ? int'(r) - 32 : int'(r);
        v    = int'(q) * int'(y) + rs;
        e.x  = v[XW-1:0];
        e.mm = (e.x != XW'(xe));
        return e;
    endfunction

    // Capture, track latency, optionally stall the consumer, then handshake.
    task automatic run(input logic [3:0] q, input logic [3:0] y, input logic [4:0] r,
                       input logic [3:0] xe, input int stall);
        int            n;
        exp_t          e;
        logic [XW-1:0] x_hold;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.Q = q; bus.Y = y; bus.R = r;
`ifdef RECON_CHECK_EN
        bus.x_exp = xe;
`endif
        sb.push_back(model(q, y, r, xe));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.Q = 4'($urandom); bus.Y = 4'($urandom); bus.R = 5'($urandom);
        for (int i = 0; i < int'(N); i++) begin
            check("calc_out_valid", 32'(bus.out_valid), 32'd0);
            check("calc_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        x_hold = bus.X;
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'b1;
            bus.Q = 4'($urandom); bus.Y = 4'($urandom); bus.R = 5'($urandom);
            @(posedge clk); #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_x", 32'(bus.X), 32'(x_hold));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("x_result", 32'(bus.X), 32'(e.x));
`ifdef RECON_CHECK_EN
            check("mismatch", 32'(bus.mismatch), 32'(e.mm));
`endif
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_hs_x_kept", 32'(bus.X), 32'(e.x));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.Q = '0; bus.Y = '0; bus.R = '0;
`ifdef RECON_CHECK_EN
        bus.x_exp = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_x", 32'(bus.X), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run(4'b0011, 4'b0010, 5'b00000, 4'd6,  0);   // 6
        run(4'b0001, 4'b1100, 5'b00001, 4'd13, 0);   // 13
        run(4'b0000, 4'b1010, 5'b00101, 4'd5,  0);   // 5, Q=0
        run(4'b0011, 4'b0011, 5'b11111, 4'd8,  0);   // 8, R=-1
        run(4'b1111, 4'b1111, 5'b01111, 4'd0,  0);   // 240, max
        run(4'b0000, 4'b0111, 5'b11101, 4'd0,  0);   // -3
        run(4'b0101, 4'b0000, 5'b10000, 4'd0,  0);   // -16, Y=0
        run(4'b1010, 4'b0110, 5'b00011, 4'd0,  7);   // 63 with 7-cycle stall
        for (int k = 0; k < 6; k++)
            run(4'($urandom), 4'($urandom), 5'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

        // Reset in the second CALC cycle drops the pending result
        bus.in_valid = 1'b1; bus.Q = 4'd5; bus.Y = 4'd5; bus.R = 5'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_x", 32'(bus.X), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run(4'd3, 4'd4, 5'd0, 4'd12, 0);              // 12

        run(4'd4, 4'd3, 5'd0, 4'd12, 0);              // mismatch 0 when enabled
        run(4'd4, 4'd3, 5'd0, 4'd13, 3);              // mismatch 1 when enabled, held

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
